// File: rtl/mem_arbiter_if.sv
// Request, response and RAM-side signals of the shared memory port.
// The arbiter uses the slave view; the CPU/RAM side uses the master view.
interface mem_arbiter_if;
    logic        halt;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ram_ready;
    logic        mem_error;

    modport slave (
        input  halt, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, mem_error
    );

    modport master (
        output halt, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, mem_error
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data has priority over fetch, with a bounded D-streak
// so fetch cannot starve, and a sticky error state on RAM timeout.
module mem_arbiter #(
    parameter int unsigned DSTREAK_MAX = 4,
    parameter int unsigned TIMEOUT     = 64
) (
    input logic          CLK,
    input logic          RST,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] IGNT = 2'd1;
    localparam logic [1:0] DGNT = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    localparam int unsigned SW = $clog2(DSTREAK_MAX + 1);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(DSTREAK_MAX);
    localparam logic [TW-1:0] TCNT_LAST  = TW'(TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic          wr_q, wr_d;
    logic          err_q, err_d;

    logic          dreq, ireq, i_own, d_own, icomp, dcomp, arb;
    logic [SW-1:0] streak_arb;

    assign dreq  = bus.dREN | bus.dWEN;
    assign ireq  = bus.iREN & ~bus.halt;
    // Ownership follows the raw request, so a halted in-flight fetch still finishes.
    assign i_own = (state_q == IGNT) & bus.iREN;
    assign d_own = (state_q == DGNT) & dreq;
    assign icomp = i_own & bus.ram_ready;
    assign dcomp = d_own & bus.ram_ready;

    assign bus.ramREN    = i_own | (d_own & ~wr_q);
    assign bus.ramWEN    = d_own & wr_q;
    assign bus.ramaddr   = (i_own | d_own) ? addr_q : '0;
    assign bus.ramstore  = (d_own & wr_q) ? data_q : '0;
    assign bus.iwait     = ~icomp;
    assign bus.dwait     = ~dcomp;
    assign bus.iload     = icomp ? bus.ramload : '0;
    assign bus.dload     = (dcomp & ~wr_q) ? bus.ramload : '0;
    assign bus.mem_error = err_q;

    always_comb begin
        state_d    = state_q;
        streak_d   = streak_q;
        tcnt_d     = tcnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wr_d       = wr_q;
        err_d      = err_q;
        arb        = 1'b0;
        streak_arb = streak_q;

        case (state_q)
            IDLE: arb = 1'b1;
            IGNT: begin
                if (!bus.iREN) begin
                    state_d = IDLE;
                    tcnt_d  = '0;
                end else if (bus.ram_ready) begin
                    streak_arb = '0;
                    arb        = 1'b1;
                end else if (tcnt_q == TCNT_LAST) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            DGNT: begin
                if (!dreq) begin
                    state_d = IDLE;
                    tcnt_d  = '0;
                end else if (bus.ram_ready) begin
                    if (ireq && streak_q != STREAK_MAX) streak_arb = streak_q + SW'(1);
                    arb = 1'b1;
                end else if (tcnt_q == TCNT_LAST) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            default: err_d = 1'b1;
        endcase

        // Arbitration uses the streak already updated by a completing D grant.
        if (arb) begin
            tcnt_d = '0;
            if (!ireq) streak_arb = '0;
            streak_d = streak_arb;
            if (dreq && (!ireq || streak_arb < STREAK_MAX)) begin
                state_d = DGNT;
                addr_d  = bus.daddr;
                data_d  = bus.dstore;
                wr_d    = bus.dWEN;
            end else if (ireq) begin
                state_d = IGNT;
                addr_d  = bus.iaddr;
                wr_d    = 1'b0;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            streak_q <= '0;
            tcnt_q   <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            tcnt_q   <= tcnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            wr_q     <= wr_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected RAM transactions,
// a negedge monitor pops and checks one entry per completion.
module tb_mem_arbiter;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    mem_arbiter_if bus();

    mem_arbiter #(.DSTREAK_MAX(4), .TIMEOUT(64)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    // RAM model: ready after ram_lat stalled cycles, read data is ~address
    int unsigned ram_lat = 0;
    logic        ram_en  = 1'b1;
    int unsigned lat_cnt = 0;
    always_comb begin
        bus.ram_ready = ram_en && (bus.ramREN || bus.ramWEN) && (lat_cnt >= ram_lat);
        bus.ramload   = ~bus.ramaddr;
    end
    always @(posedge CLK) begin
        if ((bus.ramREN || bus.ramWEN) && !bus.ram_ready) lat_cnt <= lat_cnt + 1;
        else lat_cnt <= 0;
    end

    typedef struct packed {
        logic        is_d;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t sbq[$];
    int   comp_cyc[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t e;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            if (bus.ramREN || bus.ramWEN)
                check("strobe_exclusive", 32'(bus.ramREN & bus.ramWEN), 32'd0);
            if (!bus.iwait || !bus.dwait) begin
                if (sbq.size() == 0) begin
                    check("unexpected_completion", 32'({!bus.dwait, !bus.iwait}), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    comp_cyc.push_back(cyc);
                    check("channel", 32'({!bus.dwait, !bus.iwait}), 32'({e.is_d, !e.is_d}));
                    check("ramaddr", bus.ramaddr, e.addr);
                    check("ram_op", 32'({bus.ramWEN, bus.ramREN}), 32'({e.wr, !e.wr}));
                    if (e.wr) begin
                        check("ramstore", bus.ramstore, e.data);
                        check("dload_on_write", bus.dload, 32'd0);
                    end else begin
                        check("load", e.is_d ? bus.dload : bus.iload, e.data);
                    end
                end
            end
        end
    end

    task automatic wait_comp(input string name);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge CLK);
            if (!bus.iwait || !bus.dwait) break;
        end
        if (k == 200) begin
            tests++;
            fails++;
            $display("FAIL %s: no completion within 200 cycles, expected one", name);
        end
    endtask

    task automatic idle_inputs();
        bus.halt   = 1'b0;
        bus.iREN   = 1'b0;
        bus.iaddr  = '0;
        bus.dREN   = 1'b0;
        bus.dWEN   = 1'b0;
        bus.daddr  = '0;
        bus.dstore = '0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        idle_inputs();
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    task automatic push(input logic is_d, input logic wr, input logic [31:0] addr, input logic [31:0] data);
        exp_t x;
        x.is_d = is_d;
        x.wr   = wr;
        x.addr = addr;
        x.data = data;
        sbq.push_back(x);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base;
        int strobes;
        int lows;
        logic [31:0] a;

        // reset state
        RST = 1'b1;
        idle_inputs();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_ramREN", 32'(bus.ramREN), 32'd0);
        check("rst_ramWEN", 32'(bus.ramWEN), 32'd0);
        check("rst_ramaddr", bus.ramaddr, 32'd0);
        check("rst_ramstore", bus.ramstore, 32'd0);
        check("rst_loads", bus.iload | bus.dload, 32'd0);
        check("rst_waits", 32'({bus.iwait, bus.dwait}), 32'd3);
        check("rst_mem_error", 32'(bus.mem_error), 32'd0);
        @(posedge CLK);
        #1 RST = 1'b0;

        // 1: single fetch, RAM ready one cycle after grant
        ram_lat = 1;
        bus.iREN = 1'b1;
        bus.iaddr = 32'h40;
        push(1'b0, 1'b0, 32'h40, ~32'h40);
        @(negedge CLK);
        check("t1_req_cycle_ramREN", 32'(bus.ramREN), 32'd0);
        @(negedge CLK);
        check("t1_grant_ramREN", 32'(bus.ramREN), 32'd1);
        check("t1_grant_ramaddr", bus.ramaddr, 32'h40);
        check("t1_grant_iwait", 32'(bus.iwait), 32'd1);
        wait_comp("t1");
        @(posedge CLK);
        #1 bus.iREN = 1'b0;
        @(negedge CLK);
        check("t1_iwait_after", 32'(bus.iwait), 32'd1);

        // 2: simultaneous I and D, D wins first
        do_reset();
        ram_lat = 0;
        bus.iREN = 1'b1;
        bus.iaddr = 32'h40;
        bus.dREN = 1'b1;
        bus.daddr = 32'h100;
        push(1'b1, 1'b0, 32'h100, ~32'h100);
        push(1'b0, 1'b0, 32'h40, ~32'h40);
        wait_comp("t2_d");
        @(posedge CLK);
        #1 bus.dREN = 1'b0;
        wait_comp("t2_i");
        @(posedge CLK);
        #1 bus.iREN = 1'b0;

        // 3: D streak bounded at 4 with fetch pending, back-to-back grants
        do_reset();
        ram_lat = 0;
        bus.iREN = 1'b1;
        bus.iaddr = 32'h200;
        bus.dREN = 1'b1;
        bus.daddr = 32'h300;
        for (int k = 0; k < 4; k++) begin
            a = 32'h300 + 32'(4 * k);
            push(1'b1, 1'b0, a, ~a);
        end
        push(1'b0, 1'b0, 32'h200, ~32'h200);
        push(1'b1, 1'b0, 32'h310, ~32'h310);
        base = comp_cyc.size();
        for (int k = 0; k < 6; k++) begin
            wait_comp("t3");
            if (!bus.dwait) bus.daddr = bus.daddr + 32'd4;
        end
        @(posedge CLK);
        #1;
        bus.dREN = 1'b0;
        bus.iREN = 1'b0;
        if (comp_cyc.size() >= base + 6)
            check("t3_no_bubble_span", 32'(comp_cyc[base + 5] - comp_cyc[base]), 32'd5);
        else
            check("t3_completion_count", 32'(comp_cyc.size() - base), 32'd6);

        // 4: write wins over read
        do_reset();
        bus.dREN = 1'b1;
        bus.dWEN = 1'b1;
        bus.daddr = 32'h80;
        bus.dstore = 32'hDEADBEEF;
        push(1'b1, 1'b1, 32'h80, 32'hDEADBEEF);
        wait_comp("t4");
        @(posedge CLK);
        #1;
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;

        // 5: RAM never ready -> ERR after 64 grant cycles
        do_reset();
        ram_en = 1'b0;
        bus.dREN = 1'b1;
        bus.daddr = 32'h44;
        repeat (65) @(negedge CLK);
        check("t5_last_grant_err", 32'(bus.mem_error), 32'd0);
        check("t5_last_grant_ramREN", 32'(bus.ramREN), 32'd1);
        @(negedge CLK);
        check("t5_err_flag", 32'(bus.mem_error), 32'd1);
        check("t5_err_strobes", 32'({bus.ramREN, bus.ramWEN}), 32'd0);
        check("t5_err_waits", 32'({bus.iwait, bus.dwait}), 32'd3);
        @(posedge CLK);
        #1;
        bus.dREN = 1'b0;
        bus.iREN = 1'b1;
        ram_en = 1'b1;
        repeat (4) @(negedge CLK);
        check("t5_err_sticky", 32'(bus.mem_error), 32'd1);
        check("t5_err_no_strobe", 32'(bus.ramREN), 32'd0);
        do_reset();
        @(negedge CLK);
        check("t5_rst_clears_err", 32'(bus.mem_error), 32'd0);

        // 6a: reset during a data grant aborts it
        ram_lat = 5;
        bus.dREN = 1'b1;
        bus.daddr = 32'h60;
        @(negedge CLK);
        @(negedge CLK);
        check("t6a_grant_ramREN", 32'(bus.ramREN), 32'd1);
        check("t6a_grant_dwait", 32'(bus.dwait), 32'd1);
        @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        bus.dREN = 1'b0;
        @(negedge CLK);
        check("t6a_after_rst_ramREN", 32'(bus.ramREN), 32'd0);
        check("t6a_after_rst_dwait", 32'(bus.dwait), 32'd1);
        repeat (3) @(negedge CLK);

        // 6b: halt during a fetch grant
        do_reset();
        ram_lat = 2;
        bus.iREN = 1'b1;
        bus.iaddr = 32'h90;
        push(1'b0, 1'b0, 32'h90, ~32'h90);
        @(posedge CLK);
        #1 bus.halt = 1'b1;
        wait_comp("t6b");
        strobes = 0;
        lows = 0;
        repeat (8) begin
            @(negedge CLK);
            strobes += int'(bus.ramREN);
            lows += int'(!bus.iwait);
        end
        check("t6b_halt_no_ramREN", 32'(strobes), 32'd0);
        check("t6b_halt_iwait_high", 32'(lows), 32'd0);
        idle_inputs();

        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
